fetch_align: RTL

Instruction aligner between the fetch packet buffer and the decoder bank. It accepts fetch packets of `WIDTH` words, finds instruction starts under RV compressed encoding, and drains them in order as bundles of at most `WIDTH` instructions per cycle. An uncompressed instruction that straddles two packets is stitched across packet boundaries. It handles redirects and flushes.

---
 rtl/fetch_align_pkg.sv | 17 +
 rtl/fetch_align_halfword_scan.sv | 42 ++++
 rtl/fetch_align.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_align_pkg.sv
// Shared constants, state encoding and the compressed-encoding test for the fetch aligner.
package fetch_align_pkg;

    localparam int WORD = 32;
    localparam int HALF = 16;
    localparam logic [1:0] OPC_FULL = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_e;

    function automatic logic is_compressed(input logic [1:0] opc);
        return opc != OPC_FULL;
    endfunction

endpackage

// File: rtl/fetch_align_halfword_scan.sv
// Ripple scan of a fetch packet for instruction starts under RV compressed encoding.
module fetch_align_halfword_scan
    import fetch_align_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DWIDTH = 2 * WIDTH,
    parameter int BITS   = WORD * WIDTH,
    parameter int CNT_W  = $clog2(DWIDTH + 1)
) (
    input  logic [0:BITS-1]   packet_i,
    input  logic              origin_i,
    output logic [0:DWIDTH-1] start_o,
    output logic              straddle_o,
    output logic [CNT_W-1:0]  count_o
);

    always_comb begin
        int nxt;
        int cnt;
        nxt        = origin_i ? 1 : 0;
        cnt        = 0;
        start_o    = '0;
        straddle_o = 1'b0;
        for (int j = 0; j < DWIDTH; j++) begin
            if (j == nxt) begin
                start_o[j] = 1'b1;
                if (is_compressed(packet_i[j*HALF+HALF-2 +: 2])) begin
                    nxt = j + 1;
                    cnt = cnt + 1;
                end else if (j == DWIDTH - 1) begin
                    // upper half lives in the next packet
                    straddle_o = 1'b1;
                end else begin
                    nxt = j + 2;
                    cnt = cnt + 1;
                end
            end
        end
        count_o = CNT_W'(cnt);
    end

endmodule

// File: rtl/fetch_align.sv
// Fetch-packet to decoder-bundle aligner with cross-packet stitching of 32-bit instructions.
module fetch_align
    import fetch_align_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int BITS   = WORD * WIDTH,
    parameter int DWIDTH = 2 * WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_pkt_valid,
    output logic                  o_pkt_ready,
    input  logic [0:BITS-1]       i_packet,
    input  logic [31:0]           i_pc,
    output logic [0:WIDTH-1]      o_insn_valid,
    output logic [0:WIDTH*WORD-1] o_insn,
    output logic [0:WIDTH*32-1]   o_insn_pc,
    output logic [0:WIDTH-1]      o_insn_compressed,
    input  logic                  i_dec_ready
);

    localparam int CNT_W     = $clog2(DWIDTH + 1);
    localparam int CUR_W     = $clog2(DWIDTH + 2);
    localparam int PKT_BYTES = BITS / 8;

    state_e               state_q, state_d;
    logic [0:BITS-1]      pkt_q, pkt_d;
    logic [31:0]          pc_q, pc_d;
    logic [CUR_W-1:0]     cursor_q, cursor_d;
    logic                 stitch_q, stitch_d;
    logic                 carry_v_q, carry_v_d;
    logic [HALF-1:0]      carry_hw_q, carry_hw_d;
    logic [31:0]          carry_next_pc_q, carry_next_pc_d;

    logic [0:DWIDTH-1]    start;
    logic                 straddle;
    logic [CNT_W-1:0]     scan_count;
    logic [0:DWIDTH-1]    comp;
    logic [0:DWIDTH]      cmask;
    logic [CUR_W-1:0]     total;
    logic                 last_beat;
    logic                 beat_v;
    logic [0:WIDTH-1]     lane_v;
    logic [CUR_W-1:0]     lane_pos [WIDTH];
    logic [0:BITS+HALF-1] pkt_pad;

    fetch_align_halfword_scan #(
        .WIDTH  (WIDTH),
        .DWIDTH (DWIDTH),
        .BITS   (BITS),
        .CNT_W  (CNT_W)
    ) u_scan (
        .packet_i   (pkt_q),
        .origin_i   (stitch_q),
        .start_o    (start),
        .straddle_o (straddle),
        .count_o    (scan_count)
    );

    assign pkt_pad = {pkt_q, {HALF{1'b0}}};

    // Position 0 is the stitched carry instruction, position j+1 is halfword j.
    always_comb begin
        comp     = '0;
        cmask    = '0;
        cmask[0] = stitch_q;
        for (int j = 0; j < DWIDTH; j++) begin
            comp[j]      = is_compressed(pkt_q[j*HALF+HALF-2 +: 2]);
            cmask[j + 1] = start[j];
        end
        cmask[DWIDTH] = start[DWIDTH-1] & ~straddle;
    end

    assign total     = CUR_W'(scan_count) + CUR_W'(stitch_q);
    assign last_beat = (total - cursor_q) <= CUR_W'(WIDTH);
    assign beat_v    = (state_q == HOLD) && !i_rst;
    assign o_pkt_ready = !i_rst && !i_flush &&
                         ((state_q == EMPTY) || (last_beat && i_dec_ready));

    // cursor counts consumed instructions; lane L takes the instruction of rank cursor+L.
    always_comb begin
        int r;
        r      = 0;
        lane_v = '0;
        for (int l = 0; l < WIDTH; l++) lane_pos[l] = '0;
        for (int p = 0; p <= DWIDTH; p++) begin
            if (cmask[p]) begin
                for (int l = 0; l < WIDTH; l++) begin
                    if (r == int'(cursor_q) + l) begin
                        lane_v[l]   = 1'b1;
                        lane_pos[l] = CUR_W'(p);
                    end
                end
                r = r + 1;
            end
        end
    end

    always_comb begin
        int j;
        j                 = 0;
        o_insn_valid      = '0;
        o_insn            = '0;
        o_insn_pc         = '0;
        o_insn_compressed = '0;
        for (int l = 0; l < WIDTH; l++) begin
            if (beat_v && lane_v[l]) begin
                o_insn_valid[l] = 1'b1;
                if (lane_pos[l] == '0) begin
                    o_insn[l*WORD +: WORD] = {carry_hw_q, pkt_q[0 +: HALF]};
                    o_insn_pc[l*32 +: 32]  = pc_q - 32'd2;
                end else begin
                    j = int'(lane_pos[l]) - 1;
                    o_insn_compressed[l]   = comp[j];
                    o_insn[l*WORD +: WORD] = comp[j] ? {pkt_pad[j*HALF +: HALF], {HALF{1'b0}}}
                                                     : pkt_pad[j*HALF +: WORD];
                    o_insn_pc[l*32 +: 32]  = pc_q + 32'(2 * j);
                end
            end
        end
    end

    always_comb begin
        logic            cv;
        logic [HALF-1:0] chw;
        logic [31:0]     cnpc;
        state_d  = state_q;
        pkt_d    = pkt_q;
        pc_d     = pc_q;
        cursor_d = cursor_q;
        stitch_d = stitch_q;
        cv       = carry_v_q;
        chw      = carry_hw_q;
        cnpc     = carry_next_pc_q;
        if (state_q == HOLD && i_dec_ready) begin
            if (last_beat) begin
                state_d = EMPTY;
                cv      = straddle;
                chw     = pkt_q[(DWIDTH-1)*HALF +: HALF];
                cnpc    = pc_q + 32'(PKT_BYTES);
            end else begin
                cursor_d = cursor_q + CUR_W'(WIDTH);
            end
        end
        carry_v_d       = cv;
        carry_hw_d      = chw;
        carry_next_pc_d = cnpc;
        // A packet accepted on the last beat must see the carry that beat produces.
        if (i_pkt_valid && o_pkt_ready) begin
            state_d   = HOLD;
            pkt_d     = i_packet;
            pc_d      = i_pc;
            cursor_d  = '0;
            stitch_d  = cv && (i_pc == cnpc);
            carry_v_d = 1'b0;
        end
        if (i_flush) begin
            state_d   = EMPTY;
            cursor_d  = '0;
            stitch_d  = 1'b0;
            carry_v_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= EMPTY;
            cursor_q  <= '0;
            stitch_q  <= 1'b0;
            carry_v_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cursor_q  <= cursor_d;
            stitch_q  <= stitch_d;
            carry_v_q <= carry_v_d;
        end
    end

    always_ff @(posedge i_clk) begin
        pkt_q           <= pkt_d;
        pc_q            <= pc_d;
        carry_hw_q      <= carry_hw_d;
        carry_next_pc_q <= carry_next_pc_d;
    end

endmodule
